matrix_scan_capture: RTL and testbench
======================================

Name: matrix_scan_capture

Overview:
- Receiving end of the life block's multiplexed LED interface: row (one-hot, active-high) and col (pixel data for the selected row).
- Samples the scan, rebuilds a full X*Y frame in a working buffer, and commits it atomically to a shadow buffer once every row has been seen.
- The shadow buffer is readable one row at a time. Used as a bench monitor and as an on-chip frame grabber or self-check.

Parameters:
- X, 8, columns per row (col width)
- Y, 8, number of rows (row width)
- LOG2X, 3, ceil(log2(X))
- LOG2Y, 3, ceil(log2(Y))
- TIMEOUT, 256, max cycles without a new valid row before stale asserts; minimum 2

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low
- row  in  Y  scan row select, expected one-hot or all-zero (blank)
- col  in  X  pixel data for the selected row; bit j = column j
- clr  in  1  sync clear: seen mask, err_multi, stale, frame_cnt
- rd_row  in  LOG2Y  shadow-buffer read row index
- rd_data  out  X  shadow row rd_row, registered
- frame_valid  out  1  one-cycle pulse on frame commit
- frame_cnt  out  16  committed frames, wraps at 0xFFFF->0
- err_multi  out  1  sticky: row was sampled with more than one bit set
- stale  out  1  no valid row seen for TIMEOUT cycles
- acquiring  out  1  FSM in ACQ

Behaviour:
- Reset (async, reset=0): all outputs 0; working/shadow buffers all 0; seen mask 0; FSM IDLE; timeout counter 0.
- Input stage: row and col are registered once (row_q, col_q). All decisions use the _q values, so there is 1 cycle of input latency.
- Classification of row_q:
  - zero: blank; no write.
  - one-hot at bit i: valid, index i.
  - popcount >1: invalid; no write; err_multi <= 1 (sticky).
- Bits of row above Y-1 do not exist; rd_row >= Y returns rd_data = 0.
- FSM:
  - IDLE: first valid row -> ACQ, with the write applied that cycle.
  - ACQ: each valid row i: working[i] <= col_q; seen[i] <= 1. Repeated rows overwrite, so the last value wins.
  - Commit: if a valid write makes seen all-ones, then in that same cycle:
    - shadow <= working with row i replaced by col_q;
    - seen <= 0; frame_valid <= 1 on the next cycle edge (registered pulse);
    - frame_cnt += 1; FSM stays ACQ.
  - Commit latency: col at pins to frame_valid high = 2 clk edges.
  - ACQ -> IDLE on stale assertion or clr.
- Timeout counter:
  - resets to 0 on any valid row; otherwise increments, saturating at TIMEOUT.
  - stale = (counter == TIMEOUT).
  - On stale: seen <= 0 and the partial frame is discarded; the shadow buffer is kept.
  - stale clears on the next valid row.
- clr:
  - seen <= 0, err_multi <= 0, stale <= 0, counter <= 0, frame_cnt <= 0, FSM -> IDLE; buffers kept.
  - clr has priority over a same-cycle write or commit; that sample is dropped.
- Read port: rd_data <= shadow[rd_row] every cycle, 1-cycle latency. A read in the commit cycle returns the pre-commit data; the next cycle returns new data.
- Reset mid-frame: everything returns to the reset state immediately; no partial commit.

Decomposition:
- Package life_pkg: FRAME_CNT_W = 16; FSM state enum {S_IDLE, S_ACQ}; function for one-hot/popcount classification and one-hot-to-index encoding (parameterised by Y).
- One sub-module: scan_row_decode (registered row/col in; valid, multi, idx[LOG2Y-1:0], col_q out).
- The remaining logic (FSM, buffers, timeout, read port) stays in matrix_scan_capture.

Test Plan (X=Y=8, TIMEOUT=256):
1. Reset release, then scan rows 0..7 with col=0 except row4=0x70, row5=0x40, row6=0x20, each held 1 cycle -> one frame_valid pulse 2 cycles after the row7 sample; frame_cnt=1; rd_row=4/5/6 read 0x70/0x40/0x20; other rows read 0x00.
2. Scan with rows held 8 cycles each, col changed mid-hold on row 3 (0x11 then 0x22) -> commit; shadow[3]=0x22; exactly one pulse per full scan; frame_cnt increments once per scan.
3. Drive row=0x0C once mid-scan -> err_multi=1 and stays 1; row 2/3 data unchanged; later full scan still commits. clr -> err_multi=0, frame_cnt=0.
4. Scan rows 0..5, then drive row=0 for 300 cycles -> stale=1 at cycle 256 after the last valid row; acquiring=0; no commit; shadow equals the previous frame. Next full scan -> stale=0 and a new commit.
5. Assert reset (low) mid-scan after rows 0..6 -> all outputs 0 immediately, rd_data=0 next cycle; after release, a scan of row7 alone does not commit.
6. Read shadow[2] every cycle across a commit that changes row 2 from 0x01 to 0x80 -> rd_data=0x01 in the commit cycle, 0x80 on the following cycle.

Source files
------------

// File: rtl/life_pkg.sv
// Shared types and row-classification helpers for the LED scan capture block.
// The helpers take a fixed-width row and callers zero-extend into it.
package life_pkg;

  localparam int FRAME_CNT_W = 16;
  localparam int ROW_W_MAX   = 64;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_ACQ  = 1'b1
  } scan_state_e;

  typedef enum logic [1:0] {
    ROW_BLANK  = 2'd0,
    ROW_ONEHOT = 2'd1,
    ROW_MULTI  = 2'd2
  } row_class_e;

  function automatic row_class_e row_classify(input logic [ROW_W_MAX-1:0] r);
    row_class_e c;
    case ($countones(r))
      32'd0:   c = ROW_BLANK;
      32'd1:   c = ROW_ONEHOT;
      default: c = ROW_MULTI;
    endcase
    return c;
  endfunction

  // Index of the lowest set bit; only meaningful for a one-hot input.
  function automatic int row_index(input logic [ROW_W_MAX-1:0] r);
    int idx;
    idx = 0;
    for (int i = ROW_W_MAX - 1; i >= 0; i--) begin
      if (r[i]) begin
        idx = i;
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/scan_row_decode.sv
// Input stage: registers the raw scan pins once and classifies the held row
// as blank, a valid one-hot select, or an illegal multi-row select.
module scan_row_decode
  import life_pkg::*;
#(
  parameter int X     = 8,
  parameter int Y     = 8,
  parameter int LOG2Y = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [Y-1:0]     row,
  input  logic [X-1:0]     col,
  output logic             valid,
  output logic             multi,
  output logic [LOG2Y-1:0] idx,
  output logic [X-1:0]     col_q
);

  logic [Y-1:0] row_q_r;
  logic [X-1:0] col_q_r;
  row_class_e   class_s;

  // Single sampling register for the scan pins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_q_r <= {Y{1'b0}};
      col_q_r <= {X{1'b0}};
    end else begin
      row_q_r <= row;
      col_q_r <= col;
    end
  end

  // Classification of the sampled row.
  always_comb begin
    class_s = row_classify(ROW_W_MAX'(row_q_r));
    valid   = (class_s == ROW_ONEHOT);
    multi   = (class_s == ROW_MULTI);
    idx     = LOG2Y'(row_index(ROW_W_MAX'(row_q_r)));
  end

  assign col_q = col_q_r;

endmodule

// File: rtl/matrix_scan_capture.sv
// Rebuilds full frames from a multiplexed row/col LED scan into a working buffer
// and commits each complete frame atomically into a row-readable shadow buffer.
module matrix_scan_capture
  import life_pkg::*;
#(
  parameter int X       = 8,
  parameter int Y       = 8,
  parameter int LOG2X   = 3,
  parameter int LOG2Y   = 3,
  parameter int TIMEOUT = 256
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [Y-1:0]           row,
  input  logic [X-1:0]           col,
  input  logic                   clr,
  input  logic [LOG2Y-1:0]       rd_row,
  output logic [X-1:0]           rd_data,
  output logic                   frame_valid,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic                   err_multi,
  output logic                   stale,
  output logic                   acquiring
);

  localparam int             CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  generate
    if (((1 << LOG2X) < X) || ((1 << LOG2Y) < Y) || (TIMEOUT < 2)) begin : g_bad_params
      $error("matrix_scan_capture: LOG2X/LOG2Y too small or TIMEOUT < 2");
    end
  endgenerate

  logic             valid_s;
  logic             multi_s;
  logic [LOG2Y-1:0] idx_s;
  logic [X-1:0]     col_q_s;

  scan_state_e      state_r;
  scan_state_e      state_next_s;
  logic [X-1:0]     working_r [Y];
  logic [X-1:0]     shadow_r  [Y];
  logic [Y-1:0]     seen_r;
  logic [Y-1:0]     seen_next_s;
  logic [Y-1:0]     idx_bit_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;
  logic             wr_s;
  logic             commit_s;
  logic             stale_hit_s;

  logic [X-1:0]           rd_data_r;
  logic                   frame_valid_r;
  logic [FRAME_CNT_W-1:0] frame_cnt_r;
  logic                   err_multi_r;
  logic                   stale_r;
  logic                   acquiring_r;

  scan_row_decode #(
    .X     (X),
    .Y     (Y),
    .LOG2Y (LOG2Y)
  ) u_decode (
    .clk   (clk),
    .reset (reset),
    .row   (row),
    .col   (col),
    .valid (valid_s),
    .multi (multi_s),
    .idx   (idx_s),
    .col_q (col_q_s)
  );

  // Seen-mask, commit detection and timeout; clr drops any same-cycle sample.
  always_comb begin
    idx_bit_s   = {{(Y-1){1'b0}}, 1'b1} << idx_s;
    wr_s        = valid_s & ~clr;
    seen_next_s = seen_r;
    cnt_next_s  = cnt_r;
    commit_s    = 1'b0;
    stale_hit_s = 1'b0;
    if (clr) begin
      seen_next_s = {Y{1'b0}};
      cnt_next_s  = {CNT_W{1'b0}};
    end else if (valid_s) begin
      cnt_next_s = {CNT_W{1'b0}};
      if ((seen_r | idx_bit_s) == {Y{1'b1}}) begin
        commit_s    = 1'b1;
        seen_next_s = {Y{1'b0}};
      end else begin
        seen_next_s = seen_r | idx_bit_s;
      end
    end else begin
      if (cnt_r != CNT_MAX) begin
        cnt_next_s = cnt_r + CNT_W'(1);
      end else begin
        cnt_next_s = cnt_r;
      end
      if (cnt_next_s == CNT_MAX) begin
        stale_hit_s = 1'b1;
        seen_next_s = {Y{1'b0}};
      end else begin
        stale_hit_s = 1'b0;
      end
    end
  end

  // Acquisition FSM next state.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (wr_s) begin
          state_next_s = S_ACQ;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_ACQ: begin
        if (clr || stale_hit_s) begin
          state_next_s = S_IDLE;
        end else begin
          state_next_s = S_ACQ;
        end
      end
      default: state_next_s = S_IDLE;
    endcase
  end

  // Control state and status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= S_IDLE;
      seen_r        <= {Y{1'b0}};
      cnt_r         <= {CNT_W{1'b0}};
      frame_valid_r <= 1'b0;
      frame_cnt_r   <= {FRAME_CNT_W{1'b0}};
      err_multi_r   <= 1'b0;
      stale_r       <= 1'b0;
      acquiring_r   <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      seen_r        <= seen_next_s;
      cnt_r         <= cnt_next_s;
      frame_valid_r <= commit_s;
      stale_r       <= (cnt_next_s == CNT_MAX);
      acquiring_r   <= (state_next_s == S_ACQ);
      if (clr) begin
        frame_cnt_r <= {FRAME_CNT_W{1'b0}};
        err_multi_r <= 1'b0;
      end else begin
        if (commit_s) begin
          frame_cnt_r <= frame_cnt_r + FRAME_CNT_W'(1);
        end else begin
          frame_cnt_r <= frame_cnt_r;
        end
        if (multi_s) begin
          err_multi_r <= 1'b1;
        end else begin
          err_multi_r <= err_multi_r;
        end
      end
    end
  end

  // Working buffer fill; the shadow takes the working frame with the
  // completing row patched in, since that row is only written this cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < Y; i++) begin
        working_r[i] <= {X{1'b0}};
        shadow_r[i]  <= {X{1'b0}};
      end
    end else begin
      if (wr_s) begin
        working_r[idx_s] <= col_q_s;
      end
      if (commit_s) begin
        for (int i = 0; i < Y; i++) begin
          if (LOG2Y'(i) == idx_s) begin
            shadow_r[i] <= col_q_s;
          end else begin
            shadow_r[i] <= working_r[i];
          end
        end
      end
    end
  end

  // Registered read port; out-of-range rows read as zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data_r <= {X{1'b0}};
    end else if (32'(rd_row) < Y) begin
      rd_data_r <= shadow_r[rd_row];
    end else begin
      rd_data_r <= {X{1'b0}};
    end
  end

  assign rd_data     = rd_data_r;
  assign frame_valid = frame_valid_r;
  assign frame_cnt   = frame_cnt_r;
  assign err_multi   = err_multi_r;
  assign stale       = stale_r;
  assign acquiring   = acquiring_r;

endmodule

// File: tb/tb_matrix_scan_capture.sv
// Directed bench for matrix_scan_capture (X=Y=8, TIMEOUT=256).
module tb_matrix_scan_capture;

  logic        clk;
  logic        reset;
  logic [7:0]  row;
  logic [7:0]  col;
  logic        clr;
  logic [2:0]  rd_row;
  logic [7:0]  rd_data;
  logic        frame_valid;
  logic [15:0] frame_cnt;
  logic        err_multi;
  logic        stale;
  logic        acquiring;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int pulses   = 0;
  logic [7:0] fc [8];

  matrix_scan_capture #(
    .X(8), .Y(8), .LOG2X(3), .LOG2Y(3), .TIMEOUT(256)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .row         (row),
    .col         (col),
    .clr         (clr),
    .rd_row      (rd_row),
    .rd_data     (rd_data),
    .frame_valid (frame_valid),
    .frame_cnt   (frame_cnt),
    .err_multi   (err_multi),
    .stale       (stale),
    .acquiring   (acquiring)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    if (frame_valid === 1'b1) pulses++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic scan_rows(input int first, input int last);
    for (int r = first; r <= last; r++) begin
      row = 8'b1 << r;
      col = fc[r];
      tick();
    end
  endtask

  initial begin
    reset = 1'b0; row = 8'h00; col = 8'h00; clr = 1'b0; rd_row = 3'd0;
    repeat (3) tick();
    chk("rst_rd_data", 32'(rd_data), 32'h0);
    chk("rst_frame_valid", 32'(frame_valid), 32'h0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'h0);
    chk("rst_err_multi", 32'(err_multi), 32'h0);
    chk("rst_stale", 32'(stale), 32'h0);
    chk("rst_acquiring", 32'(acquiring), 32'h0);
    reset = 1'b1;
    tick();

    // 1: single-cycle rows, commit two edges after the row7 sample
    fc = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h70, 8'h40, 8'h20, 8'h00};
    pulses = 0;
    scan_rows(0, 7);
    chk("t1_no_early_pulse", 32'(frame_valid), 32'h0);
    row = 8'h00;
    tick();
    chk("t1_frame_valid", 32'(frame_valid), 32'h1);
    chk("t1_frame_cnt", 32'(frame_cnt), 32'd1);
    chk("t1_acquiring", 32'(acquiring), 32'h1);
    tick();
    chk("t1_pulse_drop", 32'(frame_valid), 32'h0);
    chk("t1_one_pulse", 32'(pulses), 32'd1);
    for (int i = 0; i < 8; i++) begin
      rd_row = 3'(i);
      tick();
      chk($sformatf("t1_rd_row%0d", i), 32'(rd_data), 32'(fc[i]));
    end

    // 2: rows held 8 cycles, row3 data changes mid-hold
    fc = '{8'h01, 8'h02, 8'h04, 8'h00, 8'h10, 8'h20, 8'h40, 8'h80};
    pulses = 0;
    for (int r = 0; r < 8; r++) begin
      row = 8'b1 << r;
      if (r == 3) begin
        col = 8'h11; repeat (4) tick();
        col = 8'h22; repeat (4) tick();
      end else begin
        col = fc[r]; repeat (8) tick();
      end
    end
    row = 8'h00;
    tick(); tick();
    chk("t2_one_pulse", 32'(pulses), 32'd1);
    chk("t2_frame_cnt", 32'(frame_cnt), 32'd2);
    rd_row = 3'd3; tick();
    chk("t2_rd_row3_last_wins", 32'(rd_data), 32'h22);
    rd_row = 3'd7; tick();
    chk("t2_rd_row7", 32'(rd_data), 32'h80);

    // 3: multi-row select mid-scan; row7 is already seen from the long hold above
    fc = '{8'h3C, 8'h3D, 8'h5A, 8'hA5, 8'h3E, 8'h3F, 8'h40, 8'h41};
    pulses = 0;
    scan_rows(7, 7);
    scan_rows(0, 3);
    row = 8'h0C; col = 8'hFF; tick();
    scan_rows(4, 6);
    chk("t3_err_multi_set", 32'(err_multi), 32'h1);
    row = 8'h00;
    tick();
    chk("t3_frame_valid", 32'(frame_valid), 32'h1);
    chk("t3_frame_cnt", 32'(frame_cnt), 32'd3);
    tick();
    chk("t3_err_multi_sticky", 32'(err_multi), 32'h1);
    rd_row = 3'd2; tick();
    chk("t3_rd_row2", 32'(rd_data), 32'h5A);
    rd_row = 3'd3; tick();
    chk("t3_rd_row3", 32'(rd_data), 32'hA5);
    rd_row = 3'd7; tick();
    chk("t3_rd_row7", 32'(rd_data), 32'h41);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("t3_clr_err_multi", 32'(err_multi), 32'h0);
    chk("t3_clr_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("t3_clr_acquiring", 32'(acquiring), 32'h0);
    chk("t3_clr_pulses", 32'(pulses), 32'd1);

    // 6: read row2 every cycle across a commit that changes it
    fc = '{8'h11, 8'h12, 8'h01, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
    scan_rows(0, 7);
    row = 8'h00; tick();
    chk("t6_first_commit_cnt", 32'(frame_cnt), 32'd1);
    fc[2] = 8'h80;
    rd_row = 3'd2; tick();
    chk("t6_rd_before", 32'(rd_data), 32'h01);
    scan_rows(0, 7);
    row = 8'h00; tick();
    chk("t6_commit_pulse", 32'(frame_valid), 32'h1);
    chk("t6_rd_commit_cycle_old", 32'(rd_data), 32'h01);
    tick();
    chk("t6_rd_after_new", 32'(rd_data), 32'h80);
    chk("t6_frame_cnt", 32'(frame_cnt), 32'd2);

    // 4: partial frame then blank rows until stale
    fc = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6, 8'hC7};
    pulses = 0;
    scan_rows(0, 5);
    row = 8'h00;
    repeat (256) tick();
    chk("t4_stale_not_yet", 32'(stale), 32'h0);
    chk("t4_acq_before_stale", 32'(acquiring), 32'h1);
    tick();
    chk("t4_stale_set", 32'(stale), 32'h1);
    chk("t4_acq_dropped", 32'(acquiring), 32'h0);
    repeat (43) tick();
    chk("t4_stale_held", 32'(stale), 32'h1);
    chk("t4_no_commit", 32'(pulses), 32'd0);
    chk("t4_frame_cnt_kept", 32'(frame_cnt), 32'd2);
    rd_row = 3'd0; tick();
    chk("t4_shadow_row0_kept", 32'(rd_data), 32'h11);
    rd_row = 3'd2; tick();
    chk("t4_shadow_row2_kept", 32'(rd_data), 32'h80);
    fc = '{8'hE0, 8'hE1, 8'hE2, 8'hE3, 8'hE4, 8'hE5, 8'hE6, 8'hE7};
    scan_rows(0, 7);
    chk("t4_stale_cleared", 32'(stale), 32'h0);
    row = 8'h00; tick();
    chk("t4_recommit_pulse", 32'(frame_valid), 32'h1);
    chk("t4_recommit_cnt", 32'(frame_cnt), 32'd3);
    rd_row = 3'd0; tick();
    chk("t4_rd_row0_new", 32'(rd_data), 32'hE0);

    // 5: reset mid-scan, then a lone row7 must not commit
    fc = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28};
    scan_rows(0, 6);
    reset = 1'b0;
    #1;
    chk("t5_rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("t5_rst_acquiring", 32'(acquiring), 32'h0);
    chk("t5_rst_frame_valid", 32'(frame_valid), 32'h0);
    chk("t5_rst_rd_data", 32'(rd_data), 32'h0);
    tick();
    chk("t5_rst_rd_data_next", 32'(rd_data), 32'h0);
    reset = 1'b1;
    pulses = 0;
    row = 8'h80; col = 8'hAA; tick();
    row = 8'h00;
    repeat (3) tick();
    chk("t5_no_commit", 32'(pulses), 32'd0);
    chk("t5_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("t5_acquiring", 32'(acquiring), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
